// File: rtl/calib_pkg.sv
// Types shared by the calibration sequencer and the shift_accum_ram request bus.
package calib_pkg;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        WRITE_OVER = 2'd2,
        DISABLE    = 2'd3
    } accum_request_t;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETTLE      = 3'd1,
        SKIP        = 3'd2,
        WAIT_NFRAME = 3'd3,
        CAPTURE     = 3'd4,
        DONE        = 3'd5
    } calib_seq_state_t;

endpackage

// File: rtl/calibration_sequencer_if.sv
// Accumulate-request bus from the sequencer to shift_accum_ram; fire-and-forget, no ready.
interface calibration_sequencer_if #(
    parameter int ADDR_WIDTH = 18
);
    import calib_pkg::*;

    logic                  req_valid_out;
    accum_request_t        req_type_out;
    logic [ADDR_WIDTH-1:0] req_addr_out;
    logic                  req_summand_out;

    modport master (output req_valid_out, req_type_out, req_addr_out, req_summand_out);
    modport slave  (input  req_valid_out, req_type_out, req_addr_out, req_summand_out);

endinterface

// File: rtl/ds_addr_gen.sv
// Combinational: flags active, block-aligned pixels and computes their downsampled address.
module ds_addr_gen #(
    parameter int H          = 1280,
    parameter int V          = 720,
    parameter int DS_SHIFT   = 2,
    parameter int ADDR_WIDTH = 16
) (
    input  logic [10:0]           hcount,
    input  logic [9:0]            vcount,
    output logic                  pix_ok,
    output logic [ADDR_WIDTH-1:0] addr
);
    localparam logic [10:0] HMASK     = 11'((1 << DS_SHIFT) - 1);
    localparam logic [9:0]  VMASK     = 10'((1 << DS_SHIFT) - 1);
    localparam logic [31:0] ROW_PITCH = 32'(H >> DS_SHIFT);

    always_comb begin
        pix_ok = (32'(hcount) < 32'(H)) && (32'(vcount) < 32'(V))
              && ((hcount & HMASK) == '0) && ((vcount & VMASK) == '0);
        addr   = ADDR_WIDTH'(32'(hcount >> DS_SHIFT) + ROW_PITCH * 32'(vcount >> DS_SHIFT));
    end

endmodule

// File: rtl/calibration_sequencer.sv
// Walks every LED bit-plane: settle, skip frames, capture one frame; requests are registered (1 cycle), no backpressure.
// CALIB_SEQ_CONFLICT_COUNT_EN adds conflict_count_out, the number of DISABLE requests in the current step.
module calibration_sequencer
    import calib_pkg::*;
#(
    parameter int LED_ADDRESS_WIDTH  = 10,
    parameter int ACTIVE_H_PIXELS    = 1280,
    parameter int ACTIVE_LINES       = 720,
    parameter int DS_SHIFT           = 2,
    parameter int SKIP_FRAMES        = 1,
    parameter int WAIT_COUNTER_WIDTH = 24,
    localparam int STEP_WIDTH = $clog2(LED_ADDRESS_WIDTH + 1),
    localparam int ADDR_WIDTH = $clog2((ACTIVE_H_PIXELS >> DS_SHIFT) * (ACTIVE_LINES >> DS_SHIFT))
) (
    input  logic                          clk_pixel,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [WAIT_COUNTER_WIDTH-1:0] settle_cycles_in,
    input  logic [10:0]                   hcount_in,
    input  logic [9:0]                    vcount_in,
    input  logic                          new_frame_in,
    input  logic                          detect_0,
    input  logic                          detect_1,
    output calib_seq_state_t              state,
    output logic                          busy,
    output logic                          done,
    output logic [STEP_WIDTH-1:0]         step_out,
    output logic                          pattern_valid_out,
`ifdef CALIB_SEQ_CONFLICT_COUNT_EN
    output logic [ADDR_WIDTH-1:0]         conflict_count_out,
`endif
    calibration_sequencer_if.master       req
);
    localparam int WCW = WAIT_COUNTER_WIDTH;
    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(LED_ADDRESS_WIDTH - 1);
    localparam logic [WCW-1:0]        SKIP_LAST = WCW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

    calib_seq_state_t      state_d;
    logic [WCW-1:0]        cnt_q, cnt_d, settle_q, settle_d;
    logic [STEP_WIDTH-1:0] step_d;
    logic                  start_q, start_rise, settle_end;
    logic                  pix_ok, req_fire;
    logic [ADDR_WIDTH-1:0] pix_addr;
    accum_request_t        req_type_d;

    ds_addr_gen #(
        .H(ACTIVE_H_PIXELS), .V(ACTIVE_LINES), .DS_SHIFT(DS_SHIFT), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr (
        .hcount(hcount_in), .vcount(vcount_in), .pix_ok(pix_ok), .addr(pix_addr)
    );

    assign busy              = (state != IDLE) && (state != DONE);
    assign done              = (state == DONE);
    assign pattern_valid_out = busy;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        step_d     = step_out;
        start_rise = start && !start_q;
        // A zero settle time still spends one cycle in SETTLE.
        settle_end = (settle_q == '0) || (cnt_q == settle_q - WCW'(1));
        if (busy && abort) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start_rise && !abort) begin
                    state_d  = SETTLE;
                    settle_d = settle_cycles_in;
                    step_d   = '0;
                    cnt_d    = '0;
                end
                SETTLE: begin
                    cnt_d = cnt_q + WCW'(1);
                    if (settle_end) begin
                        state_d = (SKIP_FRAMES > 0) ? SKIP : WAIT_NFRAME;
                        cnt_d   = '0;
                    end
                end
                SKIP: if (new_frame_in) begin
                    if (cnt_q == SKIP_LAST) begin
                        state_d = WAIT_NFRAME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + WCW'(1);
                    end
                end
                WAIT_NFRAME: if (new_frame_in) state_d = CAPTURE;
                CAPTURE: if (new_frame_in) begin
                    if (step_out == LAST_STEP) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        step_d  = step_out + STEP_WIDTH'(1);
                        cnt_d   = '0;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The frame pulse that closes CAPTURE and an abort both suppress the request in their own cycle.
    assign req_fire   = (state == CAPTURE) && pix_ok && !new_frame_in && !abort;
    assign req_type_d = (detect_0 == detect_1) ? DISABLE :
                        (step_out == '0)       ? WRITE_OVER : WRITE;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt_q               <= '0;
            settle_q            <= '0;
            step_out            <= '0;
            start_q             <= 1'b0;
            req.req_valid_out   <= 1'b0;
            req.req_type_out    <= READ;
            req.req_addr_out    <= '0;
            req.req_summand_out <= 1'b0;
        end else begin
            state               <= state_d;
            cnt_q               <= cnt_d;
            settle_q            <= settle_d;
            step_out            <= step_d;
            start_q             <= start;
            req.req_valid_out   <= req_fire;
            req.req_type_out    <= req_fire ? req_type_d : READ;
            req.req_addr_out    <= req_fire ? pix_addr : '0;
            req.req_summand_out <= detect_1;
        end
    end

`ifdef CALIB_SEQ_CONFLICT_COUNT_EN
    logic enter_capture;
    assign enter_capture = (state == WAIT_NFRAME) && (state_d == CAPTURE);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            conflict_count_out <= '0;
        end else if (enter_capture) begin
            conflict_count_out <= '0;
        end else if (req_fire && (req_type_d == DISABLE) && (conflict_count_out != '1)) begin
            conflict_count_out <= conflict_count_out + ADDR_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_calibration_sequencer.sv
// Bench for calibration_sequencer: pixel-table vectors, hand corner sequences and a random run against an event-count model.
module tb_calibration_sequencer;
    import calib_pkg::*;

    localparam int LAW = 3, HA = 64, VA = 32, DS = 2, SKIPF = 1, WCW = 24;
    localparam int SW  = $clog2(LAW + 1);
    localparam int AW  = $clog2((HA >> DS) * (VA >> DS));
    localparam int HT  = 66, VT = 33;

    logic clk_pixel = 1'b0;
    logic rst_n, start, abort, nf, d0, d1;
    logic [WCW-1:0] settle;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    calib_seq_state_t state;
    logic busy, done, pv;
    logic [SW-1:0] step;
`ifdef CALIB_SEQ_CONFLICT_COUNT_EN
    logic [AW-1:0] ccount;
`endif

    calibration_sequencer_if #(.ADDR_WIDTH(AW)) rq ();

    calibration_sequencer #(
        .LED_ADDRESS_WIDTH(LAW), .ACTIVE_H_PIXELS(HA), .ACTIVE_LINES(VA),
        .DS_SHIFT(DS), .SKIP_FRAMES(SKIPF), .WAIT_COUNTER_WIDTH(WCW)
    ) dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .start(start), .abort(abort),
        .settle_cycles_in(settle), .hcount_in(hcount), .vcount_in(vcount),
        .new_frame_in(nf), .detect_0(d0), .detect_1(d1),
        .state(state), .busy(busy), .done(done), .step_out(step),
        .pattern_valid_out(pv),
`ifdef CALIB_SEQ_CONFLICT_COUNT_EN
        .conflict_count_out(ccount),
`endif
        .req(rq)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int gh = 0, gv = 0;
    int settle_cnt, done_cnt;
    int req_cnt [LAW];
    int first_type [LAW];

    // Reference model: counts of remaining settle cycles and frame pulses, not a state machine copy.
    bit m_busy, m_done, m_cap, m_start_q;
    int m_step, m_lat, m_settle_left, m_pulses, m_cc;
    bit e_valid, e_sum;
    int e_addr;
    accum_request_t e_type;

    typedef struct { int h; int v; bit d0; bit d1; bit vld; int addr; accum_request_t typ; } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_cap = 0; m_start_q = 0;
        m_step = 0; m_lat = 0; m_settle_left = 0; m_pulses = 0; m_cc = 0;
        e_valid = 0; e_sum = 0; e_addr = 0; e_type = READ;
    endtask

    task automatic model_edge();
        bit rise, was_cap;
        rise = start && !m_start_q;
        m_start_q = start;
        was_cap = m_busy && m_cap;
        e_valid = was_cap && !nf && !abort && (hcount < HA) && (vcount < VA)
                  && (hcount % 4 == 0) && (vcount % 4 == 0);
        e_addr  = e_valid ? (hcount / 4) + (HA / 4) * (vcount / 4) : 0;
        e_type  = !e_valid ? READ : (d0 == d1) ? DISABLE : (m_step == 0) ? WRITE_OVER : WRITE;
        e_sum   = d1;
        if (e_valid && e_type == DISABLE && m_cc < (1 << AW) - 1) m_cc++;
        if (m_done) m_done = 0;
        else if (!m_busy) begin
            if (rise && !abort) begin
                m_busy = 1; m_step = 0; m_lat = int'(settle); m_cap = 0;
                m_settle_left = (m_lat == 0) ? 1 : m_lat;
                m_pulses = SKIPF + 1;
            end
        end else if (abort) m_busy = 0;
        else if (m_settle_left > 0) m_settle_left--;
        else if (nf) begin
            if (!m_cap) begin
                m_pulses--;
                if (m_pulses == 0) begin m_cap = 1; m_cc = 0; end
            end else begin
                m_cap = 0;
                if (m_step == LAW - 1) begin m_busy = 0; m_done = 1; end
                else begin
                    m_step++;
                    m_settle_left = (m_lat == 0) ? 1 : m_lat;
                    m_pulses = SKIPF + 1;
                end
            end
        end
    endtask

    function automatic calib_seq_state_t exp_state();
        if (m_done) return DONE;
        if (!m_busy) return IDLE;
        if (m_settle_left > 0) return SETTLE;
        if (m_cap) return CAPTURE;
        if (m_pulses > 1) return SKIP;
        return WAIT_NFRAME;
    endfunction

    task automatic compare_all();
        check("state", 32'(state), 32'(exp_state()));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("step_out", 32'(step), 32'(m_step));
        check("pattern_valid", 32'(pv), 32'(m_busy));
        check("req_valid", 32'(rq.req_valid_out), 32'(e_valid));
        check("req_type", 32'(rq.req_type_out), 32'(e_type));
        if (e_valid) begin
            check("req_addr", 32'(rq.req_addr_out), 32'(e_addr));
            check("req_summand", 32'(rq.req_summand_out), 32'(e_sum));
        end
`ifdef CALIB_SEQ_CONFLICT_COUNT_EN
        check("conflict_count", 32'(ccount), 32'(m_cc));
`endif
        if (state == SETTLE) settle_cnt++;
        if (done) done_cnt++;
        if (rq.req_valid_out && m_step < LAW) begin
            req_cnt[m_step]++;
            if (first_type[m_step] < 0) first_type[m_step] = int'(rq.req_type_out);
        end
    endtask

    task automatic clear_stats();
        settle_cnt = 0; done_cnt = 0;
        for (int i = 0; i < LAW; i++) begin req_cnt[i] = 0; first_type[i] = -1; end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        model_edge();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic gen_pixel(input bit rnd);
        hcount = 11'(gh); vcount = 10'(gv);
        nf = (gh == 0 && gv == VT - 1);
        if (rnd) begin d0 = 1'($urandom); d1 = 1'($urandom); end
        else begin d0 = 1'b0; d1 = 1'b1; end
        gh++;
        if (gh == HT) begin gh = 0; gv = (gv + 1) % VT; end
    endtask

    task automatic run(input int n, input bit rnd);
        repeat (n) begin gen_pixel(rnd); tick(); end
    endtask

    task automatic do_start(input int sval, input bit rnd);
        start = 1'b1; settle = WCW'(sval);
        gen_pixel(rnd); tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; gen_pixel(0); tick(); abort = 1'b0;
    endtask

    task automatic run_until_cap(input int s, input string tag);
        int budget = 20000;
        while (!(m_busy && m_cap && m_step == s) && budget > 0) begin gen_pixel(0); tick(); budget--; end
        if (budget == 0) check(tag, 0, 1);
    endtask

    initial begin
        tbl[0]  = '{8, 4, 1, 1, 1, 18, DISABLE};
        tbl[1]  = '{60, 28, 0, 0, 1, 127, DISABLE};
        tbl[2]  = '{0, 0, 1, 0, 1, 0, WRITE_OVER};
        tbl[3]  = '{4, 0, 0, 1, 1, 1, WRITE_OVER};
        tbl[4]  = '{5, 0, 0, 1, 0, 0, READ};
        tbl[5]  = '{4, 1, 1, 1, 0, 0, READ};
        tbl[6]  = '{64, 0, 0, 1, 0, 0, READ};
        tbl[7]  = '{0, 32, 0, 1, 0, 0, READ};
        tbl[8]  = '{12, 8, 0, 1, 1, 35, WRITE_OVER};
        tbl[9]  = '{63, 31, 1, 1, 0, 0, READ};
        tbl[10] = '{20, 12, 1, 1, 1, 53, DISABLE};

        start = 0; abort = 0; settle = '0; hcount = '0; vcount = '0; nf = 0; d0 = 0; d1 = 0;
        rst_n = 1'b0;
        model_reset(); clear_stats();
        #23;
        compare_all();
        @(negedge clk_pixel); rst_n = 1'b1;

        // Full three-plane walk with every pixel lit.
        clear_stats();
        do_start(5, 0);
        begin
            int budget = 30000;
            while ((m_busy || m_done) && budget > 0) begin gen_pixel(0); tick(); budget--; end
            if (budget == 0) check("full_run_timeout", 0, 1);
        end
        for (int i = 0; i < LAW; i++) check($sformatf("req_count_step%0d", i), 32'(req_cnt[i]), 32'd128);
        check("first_type_step0", 32'(first_type[0]), 32'(WRITE_OVER));
        check("first_type_step1", 32'(first_type[1]), 32'(WRITE));
        check("first_type_step2", 32'(first_type[2]), 32'(WRITE));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("settle_cycles_total", 32'(settle_cnt), 32'd15);

        // Pixel table applied inside a step-0 capture window.
        do_start(2, 0);
        run_until_cap(0, "table_cap_timeout");
        for (int i = 0; i < 11; i++) begin
            hcount = 11'(tbl[i].h); vcount = 10'(tbl[i].v); nf = 0; d0 = tbl[i].d0; d1 = tbl[i].d1;
            tick();
            check($sformatf("tbl%0d_valid", i), 32'(rq.req_valid_out), 32'(tbl[i].vld));
            check($sformatf("tbl%0d_type", i), 32'(rq.req_type_out), 32'(tbl[i].typ));
            if (tbl[i].vld) check($sformatf("tbl%0d_addr", i), 32'(rq.req_addr_out), 32'(tbl[i].addr));
        end
        for (int k = 0; k < 7; k++) begin
            hcount = 11'(4 * k); vcount = 10'd16; nf = 0; d0 = 1; d1 = 1;
            tick();
        end
        hcount = 11'd4; vcount = 10'd8; nf = 1; d0 = 1; d1 = 1;
        tick();
        check("capture_end_pixel_dropped", 32'(rq.req_valid_out), 32'd0);
`ifdef CALIB_SEQ_CONFLICT_COUNT_EN
        check("conflicts_step0", 32'(ccount), 32'd10);
`endif
        run_until_cap(1, "step1_cap_timeout");
`ifdef CALIB_SEQ_CONFLICT_COUNT_EN
        check("conflicts_cleared_step1", 32'(ccount), 32'd0);
`endif
        do_abort();

        // Settle length for 0 and 7.
        for (int t = 0; t < 2; t++) begin
            int sv, budget;
            sv = (t == 0) ? 0 : 7;
            clear_stats();
            do_start(sv, 0);
            budget = 100;
            while (m_busy && m_settle_left > 0 && budget > 0) begin gen_pixel(0); tick(); budget--; end
            check($sformatf("settle_len_%0d", sv), 32'(settle_cnt), (t == 0) ? 32'd1 : 32'd7);
            do_abort();
        end

        // Abort in the middle of the step-1 capture, then a clean restart.
        clear_stats();
        do_start(3, 0);
        run_until_cap(1, "abort_cap_timeout");
        run(200, 0);
        do_abort();
        check("abort_state", 32'(state), 32'(IDLE));
        check("abort_req_valid", 32'(rq.req_valid_out), 32'd0);
        run(5, 0);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        clear_stats();
        do_start(3, 0);
        run_until_cap(0, "restart_cap_timeout");
        begin
            int budget = 3000;
            while (first_type[0] < 0 && budget > 0) begin gen_pixel(0); tick(); budget--; end
            check("restart_step", 32'(step), 32'd0);
            check("restart_type", 32'(first_type[0]), 32'(WRITE_OVER));
        end
        do_abort();

        // Asynchronous reset between clock edges in SETTLE.
        do_start(20, 0);
        run(3, 0);
        #3 rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        check("async_rst_state", 32'(state), 32'(IDLE));
        @(posedge clk_pixel);
        @(negedge clk_pixel); rst_n = 1'b1;

        // Start re-asserted while busy is ignored.
        do_start(4, 0);
        begin
            int budget = 100;
            while (m_busy && m_settle_left > 0 && budget > 0) begin gen_pixel(0); tick(); budget--; end
        end
        start = 1'b1; gen_pixel(0); tick();
        start = 1'b0; gen_pixel(0); tick();
        check("start_busy_state", 32'(state), 32'(SKIP));
        check("start_busy_step", 32'(step), 32'd0);
        do_abort();

        // Randomized run: random detections, settle times, starts and rare aborts.
        for (int c = 0; c < 15000; c++) begin
            start  = (!m_busy && ($urandom_range(0, 40) == 0));
            abort  = ($urandom_range(0, 4000) == 0);
            settle = WCW'($urandom_range(0, 12));
            gen_pixel(1);
            tick();
        end
        start = 0; abort = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/calibration_sequencer.md
Name: calibration_sequencer

Overview:
- Multi-step successor to the single-step calibration FSM. Walks all LED_ADDRESS_WIDTH bit-planes of the LED address code automatically: drives the bit-plane index to the LED pattern driver, waits a runtime-set settle time, skips a set number of camera frames, then captures one frame.
- During capture it emits one downsampled accumulate request per DS_SHIFT-aligned pixel to the external shift_accum_ram.
- Sits between the camera timing/threshold detectors and the accumulator RAM.

Parameters:
- LED_ADDRESS_WIDTH, 10: number of bit-plane steps (one per address bit).
- ACTIVE_H_PIXELS, 1280: active line width.
- ACTIVE_LINES, 720: active frame height.
- DS_SHIFT, 2: downsample shift; one request per 2^DS_SHIFT x 2^DS_SHIFT block.
- SKIP_FRAMES, 1: whole frames discarded after settle, before capture (0 allowed).
- WAIT_COUNTER_WIDTH, 24: width of the settle counter.
- STEP_WIDTH (local), $clog2(LED_ADDRESS_WIDTH+1).
- ADDR_WIDTH (local), $clog2((ACTIVE_H_PIXELS>>DS_SHIFT)*(ACTIVE_LINES>>DS_SHIFT)).

Ports:
- clk_pixel  in  1  pixel clock, only clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sequence; rising-edge detected.
- abort  in  1  level; cancel the sequence.
- settle_cycles_in  in  WAIT_COUNTER_WIDTH  LED settle time in cycles; latched on start.
- hcount_in  in  11  pixel column.
- vcount_in  in  10  pixel row.
- new_frame_in  in  1  single-cycle frame-start pulse.
- detect_0  in  1  pixel classified as LED off.
- detect_1  in  1  pixel classified as LED on.
- state  out  calib_seq_state_t  current FSM state.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the last step's capture completes.
- step_out  out  STEP_WIDTH  current bit-plane index.
- pattern_valid_out  out  1  LED driver should display bit-plane step_out (high in SETTLE through CAPTURE).
- req_valid_out  out  1  accumulate request valid.
- req_type_out  out  accum_request_t  READ/WRITE/WRITE_OVER/DISABLE.
- req_addr_out  out  ADDR_WIDTH  downsampled pixel address.
- req_summand_out  out  1  equals detect_1.

Behaviour:
- Reset values (async on rst_n low): state=IDLE, all outputs 0, req_type_out=READ, all counters 0, start edge register 0.
- States: IDLE, SETTLE, SKIP, WAIT_NFRAME, CAPTURE, DONE.
- IDLE: on start rising edge, latch settle_cycles_in, step_out<=0, go to SETTLE with counter 0. Start while busy is ignored.
- SETTLE: counter increments each cycle. Exit when counter==latched-1, or immediately next cycle if latched==0. Exit goes to SKIP if SKIP_FRAMES>0, else WAIT_NFRAME.
- SKIP: count new_frame_in pulses; after SKIP_FRAMES pulses go to WAIT_NFRAME.
- WAIT_NFRAME: on new_frame_in go to CAPTURE.
- CAPTURE: on next new_frame_in, if step_out==LED_ADDRESS_WIDTH-1 go to DONE; else step_out<=step_out+1 and go to SETTLE (counter 0).
- DONE: done=1 for exactly one cycle, then IDLE. step_out holds its last value until the next start.
- abort, level-sensitive, in any busy state: next cycle state=IDLE, req_valid_out=0, no done pulse. abort wins over start and over new_frame_in in the same cycle.
- Request generation, registered, 1-cycle latency from hcount_in/vcount_in:
  - valid when state==CAPTURE, hcount_in<ACTIVE_H_PIXELS, vcount_in<ACTIVE_LINES, and low DS_SHIFT bits of both counts are 0.
  - req_addr_out = (hcount_in>>DS_SHIFT) + (ACTIVE_H_PIXELS>>DS_SHIFT)*(vcount_in>>DS_SHIFT), truncated to ADDR_WIDTH.
  - req_type_out = DISABLE if detect_0==detect_1; else WRITE_OVER if step_out==0; else WRITE. When invalid, req_type_out=READ and req_valid_out=0.
- The new_frame_in that ends CAPTURE suppresses requests from that cycle on. The pixel coincident with the pulse is not captured.
- A new_frame_in arriving in the same cycle SETTLE finishes is not counted; counting starts the following cycle.

Optional Feature:
- CALIB_SEQ_CONFLICT_COUNT_EN: adds output conflict_count_out [ADDR_WIDTH] = number of DISABLE requests issued in the current step. Cleared on entry to CAPTURE; saturates at all-ones; holds its value after CAPTURE exits. Reset to 0.
- Without the macro: port absent, no counter logic.

Decomposition:
- Package calib_pkg: accum_request_t (READ, WRITE, WRITE_OVER, DISABLE; shared with shift_accum_ram) and calib_seq_state_t.
- Sub-module ds_addr_gen: combinational active/aligned test plus address computation, parametrised by H, V, DS_SHIFT. The FSM and output registers stay in calibration_sequencer.

Test Plan:
- LED_ADDRESS_WIDTH=3, settle=5, SKIP_FRAMES=1, 64x32 frame, DS_SHIFT=2, detect_1=1/detect_0=0 -> 3 captures; step_out 0,1,2; 128 valid requests per step; step 0 type WRITE_OVER, steps 1-2 WRITE; one done pulse.
- Pixel (8,4) with detect_0=detect_1=1 during capture -> req_addr_out=18, req_type_out=DISABLE, one cycle after the inputs.
- settle_cycles_in=0 -> SETTLE lasts 1 cycle; settle=7 -> exactly 7 cycles in SETTLE, verified by cycle count.
- abort asserted mid-CAPTURE of step 1 -> IDLE next cycle, req_valid_out=0, no done; a later start restarts at step 0 with WRITE_OVER.
- rst_n pulsed low asynchronously mid-SETTLE (between clock edges) -> all outputs 0 immediately, state=IDLE; start while busy -> ignored.
- With CALIB_SEQ_CONFLICT_COUNT_EN: 10 conflict pixels in step 0 -> conflict_count_out=10 after capture; cleared to 0 on entry to CAPTURE of step 1.
